frame_capture_ctrl: RTL and testbench
=====================================

// Module: frame_capture_ctrl
// PURPOSE
//  Avalon-MM slave that sequences single-frame capture from the VGA pixel stream for the HPS.
//  Arms on a CPU command and waits for a frame start (VSYNC falling edge).
//  Buffers active pixels in an internal FIFO that the CPU drains over the bus.
//  Reports state, fill level and errors. Sits between the VGA output pipeline and the lightweight HPS bridge.
// PARAMETERS
//  FIFO_DEPTH   16       pixel FIFO entries; power of two, >=4
//  MAX_PIXELS   307200   active pixels per capture (640x480); capture ends when reached
// PORTS
//  clk        in   1   system clock; VGA stream is synchronous to it
//  reset      in   1   asynchronous, active-low reset
//  writedata  in   32  bus write data
//  write      in   1   bus write strobe
//  chipselect in   1   slave select
//  address    in   2   register index
//  read       in   1   bus read strobe
//  readdata   out  32  bus read data, combinational decode (read latency 0)
//  VGA_R/G/B  in   8   pixel colour, each 8 bits
//  VGA_BLANK_n in  1   high = active pixel region
//  pix_en     in   1   one-cycle pixel strobe; a pixel is sampled only when high
//  HSYNC      in   1   active-low horizontal sync
//  VSYNC      in   1   active-low vertical sync
// BEHAVIOUR
//  Reset (reset low, async): state=IDLE, FIFO empty, pix_count=0, overflow=0, readdata decodes from cleared regs.
//  Registers (chipselect qualifies all accesses):
//   0 CTRL   W: bit0 start, bit1 abort. R: 0.
//   1 STATUS R: [1:0] state (IDLE=0, WAIT_VS=1, CAPTURE=2, DONE=3), [4] empty, [5] full, [6] overflow, [15:8] fifo level.
//   2 PIXEL  R: FIFO head {R,G,B,8'd0}; pop on the read-cycle clock edge. Empty -> 32'd0, no pop.
//   3 COUNT  R: pix_count, 32 bits.
//  vs_fall = VSYNC_q & ~VSYNC, where VSYNC_q is VSYNC registered one cycle.
//  FSM transitions:
//   IDLE    : start -> WAIT_VS; flush FIFO, pix_count=0, overflow=0.
//   WAIT_VS : vs_fall -> CAPTURE. No pixels pushed in the vs_fall cycle.
//   CAPTURE : pixel = pix_en & VGA_BLANK_n & HSYNC & VSYNC.
//             Each pixel -> pix_count+1. Push if not full, else drop and set overflow (sticky).
//             pix_count reaches MAX_PIXELS (after increment) -> DONE.
//             Also vs_fall before MAX_PIXELS -> DONE (short frame).
//   DONE    : hold. CPU may drain FIFO. start -> WAIT_VS with the same clears as in IDLE.
//  Start outside IDLE/DONE is ignored.
//  Abort, any state -> IDLE next cycle; flush FIFO, pix_count=0, overflow=0. Abort wins over start in the same write.
//  Push and pop in the same cycle:
//   full  -> both happen; level unchanged; no overflow.
//   empty -> pop ignored and read returns 0; push stored; level becomes 1.
//  FIFO pointers wrap modulo FIFO_DEPTH. Level is 0..FIFO_DEPTH, zero-extended in STATUS.
//  pix_count saturates at MAX_PIXELS. It never wraps.
//  Reset asserted mid-capture: immediate return to the reset values above. Buffered data is lost.
//  Reads of STATUS/COUNT have no side effects. Writes to addresses 1-3 are ignored.
// CONFIGURATION
//  FRAME_CAP_IRQ_EN defined:
//   Adds output irq (1 bit, reset 0).
//   irq set on entry to DONE, and on overflow 0->1.
//   Cleared by a CTRL write with bit2=1, or by abort.
//  FRAME_CAP_IRQ_EN undefined: no irq port; CTRL bit2 ignored; the CPU polls STATUS.
// TESTING
//  1 Reset low mid-CAPTURE -> next cycle STATUS=0x0000_0010, COUNT=0.
//  2 MAX_PIXELS=8, DEPTH=16: start, VSYNC 1->0, 8 active pixels 0x11..0x88 -> state=DONE;
//    8 PIXEL reads return 0x11..0x88 in order; 9th read returns 0.
//  3 DEPTH=4, 6 pixels, no reads -> level=4, full=1, overflow=1, COUNT=6.
//  4 Full FIFO, PIXEL read coincident with pixel push -> level stays 4, overflow stays 0.
//  5 Start then abort in WAIT_VS; also write 0x3 -> state=IDLE both cases; no capture on the next vs_fall.
//  6 FRAME_CAP_IRQ_EN: DONE -> irq=1; CTRL write 0x4 -> irq=0; overflow also raises irq.

Source files
------------

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: Avalon-MM sequencer that captures one VGA frame into a CPU-drained pixel FIFO.
// Optional FRAME_CAP_IRQ_EN adds an irq output raised on DONE entry or first overflow.
module frame_capture_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_PIXELS = 307200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] writedata,
    input  logic        write,
    input  logic        chipselect,
    input  logic [1:0]  address,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B,
    input  logic        VGA_BLANK_n,
    input  logic        pix_en,
    input  logic        HSYNC,
    input  logic        VSYNC
`ifdef FRAME_CAP_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

    state_t          state, state_nxt;
    logic [23:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level;
    logic [31:0]     pix_count, count_inc;
    logic            overflow, vsync_q;
    logic            ctrl_wr, abort, start, flush, vs_fall, pixel, empty, full, pop, push, drop;
    logic            unused_bits;

    assign ctrl_wr     = chipselect && write && address == 2'd0;
    assign abort       = ctrl_wr && writedata[1];
    assign start       = ctrl_wr && writedata[0] && !writedata[1] && (state == IDLE || state == DONE);
    assign flush       = abort || start;
    assign vs_fall     = vsync_q && !VSYNC;
    assign pixel       = state == CAPTURE && pix_en && VGA_BLANK_n && HSYNC && VSYNC;
    assign empty       = level == '0;
    assign full        = level == LW'(FIFO_DEPTH);
    assign pop         = chipselect && read && address == 2'd2 && !empty;
    // a pop frees the slot the push lands in, so a full FIFO can still accept
    assign push        = pixel && (!full || pop);
    assign drop        = pixel && full && !pop;
    assign count_inc   = (pix_count == 32'(MAX_PIXELS)) ? pix_count : pix_count + 32'd1;
    assign unused_bits = ^writedata[31:2];

    always_comb begin
        state_nxt = state;
        if (abort)
            state_nxt = IDLE;
        else if (start)
            state_nxt = WAIT_VS;
        else if (state == WAIT_VS && vs_fall)
            state_nxt = CAPTURE;
        else if (state == CAPTURE && (vs_fall || (pixel && count_inc == 32'(MAX_PIXELS))))
            state_nxt = DONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_q   <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            pix_count <= '0;
            overflow  <= 1'b0;
        end else begin
            vsync_q <= VSYNC;
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level     <= '0;
                pix_count <= '0;
                overflow  <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                level <= level + LW'(push) - LW'(pop);
                if (pixel)
                    pix_count <= count_inc;
                if (drop)
                    overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= {VGA_R, VGA_G, VGA_B};
    end

`ifdef FRAME_CAP_IRQ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            irq <= 1'b0;
        else if (abort)
            irq <= 1'b0;
        else if ((state_nxt == DONE && state != DONE) || (drop && !overflow))
            irq <= 1'b1;
        else if (ctrl_wr && writedata[2])
            irq <= 1'b0;
    end
`endif

    always_comb begin
        readdata = 32'd0;
        if (address == 2'd1)
            readdata = {16'd0, 8'(level), 1'b0, overflow, full, empty, 2'b00, state};
        else if (address == 2'd2)
            readdata = empty ? 32'd0 : {mem[rd_ptr], 8'd0};
        else if (address == 2'd3)
            readdata = pix_count;
    end
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb_frame_capture_ctrl: two capture instances (16-deep/8-pixel and 4-deep/20-pixel) checked
// against a queue-based model of the capture rules.
module tb_frame_capture_ctrl;
    logic        clk = 0;
    logic        reset = 0;
    logic [31:0] writedata = 0;
    logic        write = 0, read = 0;
    logic [1:0]  cs = 0;
    logic [1:0]  address = 0;
    logic [7:0]  VGA_R = 0, VGA_G = 0, VGA_B = 0;
    logic        VGA_BLANK_n = 1, pix_en = 0, HSYNC = 1, VSYNC = 1;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;

    int ntests = 0, nfail = 0;

    int          depth [2] = '{16, 4};
    int          maxp [2]  = '{8, 20};
    int          st [2], cnt [2];
    bit          ovf [2], irqm [2];
    logic [23:0] q [2][$];
    bit          vq;

    always #5 clk = ~clk;

    frame_capture_ctrl #(.FIFO_DEPTH(16), .MAX_PIXELS(8)) u_a (
        .clk(clk), .reset(reset), .writedata(writedata), .write(write), .chipselect(cs[0]),
        .address(address), .read(read), .readdata(rd_a), .VGA_R(VGA_R), .VGA_G(VGA_G),
        .VGA_B(VGA_B), .VGA_BLANK_n(VGA_BLANK_n), .pix_en(pix_en), .HSYNC(HSYNC), .VSYNC(VSYNC)
`ifdef FRAME_CAP_IRQ_EN
        , .irq(irq_a)
`endif
    );

    frame_capture_ctrl #(.FIFO_DEPTH(4), .MAX_PIXELS(20)) u_b (
        .clk(clk), .reset(reset), .writedata(writedata), .write(write), .chipselect(cs[1]),
        .address(address), .read(read), .readdata(rd_b), .VGA_R(VGA_R), .VGA_G(VGA_G),
        .VGA_B(VGA_B), .VGA_BLANK_n(VGA_BLANK_n), .pix_en(pix_en), .HSYNC(HSYNC), .VSYNC(VSYNC)
`ifdef FRAME_CAP_IRQ_EN
        , .irq(irq_b)
`endif
    );

`ifndef FRAME_CAP_IRQ_EN
    assign irq_a = 1'b0;
    assign irq_b = 1'b0;
`endif

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            st[i] = 0; cnt[i] = 0; ovf[i] = 0; irqm[i] = 0; q[i].delete();
        end
        vq = 1;
    endtask

    task automatic model_step(input int i);
        bit ctrl, ab, go, vsf, pix, pop;
        ctrl = cs[i] && write && address == 0;
        ab   = ctrl && writedata[1];
        go   = ctrl && writedata[0] && !writedata[1] && (st[i] == 0 || st[i] == 3);
        vsf  = vq && !VSYNC;
        pix  = st[i] == 2 && pix_en && VGA_BLANK_n && HSYNC && VSYNC;
        pop  = cs[i] && read && address == 2 && q[i].size() > 0;
        if (ab) begin
            st[i] = 0; q[i].delete(); cnt[i] = 0; ovf[i] = 0; irqm[i] = 0;
        end else begin
            if (ctrl && writedata[2]) irqm[i] = 0;
            if (go) begin
                st[i] = 1; q[i].delete(); cnt[i] = 0; ovf[i] = 0;
            end else begin
                if (pop) void'(q[i].pop_front());
                if (pix) begin
                    if (cnt[i] < maxp[i]) cnt[i]++;
                    if (q[i].size() < depth[i]) q[i].push_back({VGA_R, VGA_G, VGA_B});
                    else begin
                        if (!ovf[i]) irqm[i] = 1;
                        ovf[i] = 1;
                    end
                end
                if (st[i] == 1 && vsf) st[i] = 2;
                else if (st[i] == 2 && (vsf || (pix && cnt[i] == maxp[i]))) begin
                    st[i] = 3; irqm[i] = 1;
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_status(input int i);
        int n = q[i].size();
        return {16'd0, 8'(n), 1'b0, ovf[i], n == depth[i], n == 0, 2'b00, 2'(st[i])};
    endfunction

    function automatic logic [31:0] exp_read(input int i, input logic [1:0] a);
        if (a == 1) return exp_status(i);
        if (a == 2) return q[i].size() > 0 ? {q[i][0], 8'd0} : 32'd0;
        if (a == 3) return 32'(cnt[i]);
        return 32'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else begin
            model_step(0); model_step(1); vq = VSYNC;
        end
        @(negedge clk);
        write = 0; read = 0; cs = 0; pix_en = 0;
    endtask

    task automatic peek(input int i, input logic [1:0] a, output logic [31:0] v);
        address = a;
        #1;
        v = i ? rd_b : rd_a;
    endtask

    task automatic bus_write(input int i, input logic [31:0] d);
        cs[i] = 1; write = 1; address = 0; writedata = d;
        step();
    endtask

    task automatic vs_pulse();
        VSYNC = 0;
        step();
        VSYNC = 1;
    endtask

    task automatic pixel(input logic [23:0] rgb);
        pix_en = 1; VGA_BLANK_n = 1; HSYNC = 1; VSYNC = 1;
        {VGA_R, VGA_G, VGA_B} = rgb;
        step();
    endtask

    task automatic read_pixel(input int i, output logic [31:0] v);
        cs[i] = 1; read = 1; address = 2;
        #1;
        v = i ? rd_b : rd_a;
        step();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            peek(i, 1, v);
            ntests++;
            if (v !== 32'h10) begin nfail++; $display("FAIL reset_status[%0d] got %h want %h", i, v, 32'h10); end
            peek(i, 3, v);
            ntests++;
            if (v !== 32'h0) begin nfail++; $display("FAIL reset_count[%0d] got %h want 0", i, v); end
        end
    endtask

    task automatic test_frame();
        logic [31:0] v, want;
        logic [7:0]  c;
        bus_write(0, 1);
        peek(0, 1, v);
        ntests++;
        if (v !== 32'h11) begin nfail++; $display("FAIL frame_wait got %h want %h", v, 32'h11); end
        vs_pulse();
        for (int k = 1; k <= 8; k++) begin
            repeat ($urandom_range(0, 2)) begin
                pix_en = 1; VGA_BLANK_n = 0;
                step();
                VGA_BLANK_n = 1;
            end
            c = 8'(k * 17);
            pixel({c, c, c});
        end
        peek(0, 1, v);
        ntests++;
        if (v !== 32'h0803 || v !== exp_status(0)) begin nfail++; $display("FAIL frame_done got %h want %h", v, 32'h0803); end
        peek(0, 3, v);
        ntests++;
        if (v !== 32'd8) begin nfail++; $display("FAIL frame_count got %0d want 8", v); end
        for (int k = 1; k <= 9; k++) begin
            c = 8'(k * 17);
            want = (k == 9) ? 32'd0 : {c, c, c, 8'd0};
            read_pixel(0, v);
            ntests++;
            if (v !== want) begin nfail++; $display("FAIL frame_read%0d got %h want %h", k, v, want); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        bus_write(1, 1);
        vs_pulse();
        for (int k = 0; k < 6; k++) pixel(24'($urandom));
        peek(1, 1, v);
        ntests++;
        if (v !== 32'h0462 || v !== exp_status(1)) begin nfail++; $display("FAIL ovf_status got %h want %h", v, 32'h0462); end
        peek(1, 3, v);
        ntests++;
        if (v !== 32'd6) begin nfail++; $display("FAIL ovf_count got %0d want 6", v); end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] v;
        logic [23:0] d [5];
        bus_write(1, 2);
        bus_write(1, 1);
        vs_pulse();
        for (int k = 0; k < 5; k++) d[k] = 24'($urandom);
        for (int k = 0; k < 4; k++) pixel(d[k]);
        peek(1, 1, v);
        ntests++;
        if (v !== 32'h0422) begin nfail++; $display("FAIL ppf_full got %h want %h", v, 32'h0422); end
        cs[1] = 1; read = 1; address = 2;
        pix_en = 1; {VGA_R, VGA_G, VGA_B} = d[4];
        #1;
        v = rd_b;
        step();
        ntests++;
        if (v !== {d[0], 8'd0}) begin nfail++; $display("FAIL ppf_pop got %h want %h", v, {d[0], 8'd0}); end
        peek(1, 1, v);
        ntests++;
        if (v !== 32'h0422) begin nfail++; $display("FAIL ppf_level got %h want %h", v, 32'h0422); end
        for (int k = 1; k < 5; k++) begin
            read_pixel(1, v);
            ntests++;
            if (v !== {d[k], 8'd0}) begin nfail++; $display("FAIL ppf_drain%0d got %h want %h", k, v, {d[k], 8'd0}); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] v;
        bus_write(0, 1);
        peek(0, 1, v);
        ntests++;
        if (v !== 32'h11) begin nfail++; $display("FAIL abort_arm got %h want %h", v, 32'h11); end
        bus_write(0, 2);
        peek(0, 1, v);
        ntests++;
        if (v !== 32'h10) begin nfail++; $display("FAIL abort_idle got %h want %h", v, 32'h10); end
        bus_write(0, 1);
        bus_write(0, 3);
        peek(0, 1, v);
        ntests++;
        if (v !== 32'h10) begin nfail++; $display("FAIL abort_win got %h want %h", v, 32'h10); end
        vs_pulse();
        for (int k = 0; k < 3; k++) pixel(24'($urandom));
        peek(0, 1, v);
        ntests++;
        if (v !== 32'h10) begin nfail++; $display("FAIL abort_nocap got %h want %h", v, 32'h10); end
        peek(0, 3, v);
        ntests++;
        if (v !== 32'd0) begin nfail++; $display("FAIL abort_count got %0d want 0", v); end
    endtask

`ifdef FRAME_CAP_IRQ_EN
    task automatic test_irq();
        bus_write(0, 2);
        bus_write(1, 2);
        ntests++;
        if (irq_a !== 1'b0) begin nfail++; $display("FAIL irq_abort got %b want 0", irq_a); end
        bus_write(0, 1);
        vs_pulse();
        for (int k = 0; k < 8; k++) pixel(24'($urandom));
        ntests++;
        if (irq_a !== 1'b1) begin nfail++; $display("FAIL irq_done got %b want 1", irq_a); end
        bus_write(0, 4);
        ntests++;
        if (irq_a !== 1'b0) begin nfail++; $display("FAIL irq_clear got %b want 0", irq_a); end
        bus_write(1, 1);
        vs_pulse();
        for (int k = 0; k < 4; k++) pixel(24'($urandom));
        ntests++;
        if (irq_b !== 1'b0) begin nfail++; $display("FAIL irq_nofull got %b want 0", irq_b); end
        pixel(24'($urandom));
        ntests++;
        if (irq_b !== 1'b1) begin nfail++; $display("FAIL irq_ovf got %b want 1", irq_b); end
    endtask
`endif

    task automatic test_random();
        int          vs_low = 0, i, r;
        logic [31:0] v, e;
        for (int c = 0; c < 1500; c++) begin
            if (vs_low > 0) begin VSYNC = 0; vs_low--; end
            else begin
                VSYNC = 1;
                if ($urandom_range(0, 29) == 0) vs_low = $urandom_range(1, 3);
            end
            HSYNC       = $urandom_range(0, 9) != 0;
            VGA_BLANK_n = $urandom_range(0, 7) != 0;
            pix_en      = 1'($urandom_range(0, 1));
            {VGA_R, VGA_G, VGA_B} = 24'($urandom);
            i = $urandom_range(0, 1);
            r = $urandom_range(0, 5);
            if (r == 0) begin
                r = $urandom_range(0, 9);
                writedata = r < 5 ? 32'd1 : r == 5 ? 32'd2 : r == 6 ? 32'd4 : r == 7 ? 32'd5 : $urandom;
                address = $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'd0;
                cs[i] = 1; write = 1;
            end else if (r < 3) begin
                r = $urandom_range(0, 4);
                address = r > 3 ? 2'd2 : 2'(r);
                cs[i] = 1; read = 1;
                #1;
                v = i ? rd_b : rd_a;
                e = exp_read(i, address);
                ntests++;
                if (v !== e) begin nfail++; $display("FAIL rnd_read[%0d] c%0d a%0d got %h want %h", i, c, address, v, e); end
            end
            step();
            i = c % 2;
            peek(i, 1, v);
            ntests++;
            if (v !== exp_status(i)) begin nfail++; $display("FAIL rnd_status[%0d] c%0d got %h want %h", i, c, v, exp_status(i)); end
            peek(i, 3, v);
            ntests++;
            if (v !== 32'(cnt[i])) begin nfail++; $display("FAIL rnd_count[%0d] c%0d got %0d want %0d", i, c, v, cnt[i]); end
`ifdef FRAME_CAP_IRQ_EN
            ntests++;
            if ((i ? irq_b : irq_a) !== irqm[i]) begin nfail++; $display("FAIL rnd_irq[%0d] c%0d got %b want %b", i, c, i ? irq_b : irq_a, irqm[i]); end
`endif
        end
        VSYNC = 1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        bus_write(0, 2);
        bus_write(0, 1);
        vs_pulse();
        for (int k = 0; k < 3; k++) pixel(24'($urandom));
        peek(0, 1, v);
        ntests++;
        if (v !== 32'h0302) begin nfail++; $display("FAIL rmid_capture got %h want %h", v, 32'h0302); end
        reset = 0;
        model_reset();
        peek(0, 1, v);
        ntests++;
        if (v !== 32'h10) begin nfail++; $display("FAIL rmid_async got %h want %h", v, 32'h10); end
        step();
        peek(0, 1, v);
        ntests++;
        if (v !== 32'h10) begin nfail++; $display("FAIL rmid_status got %h want %h", v, 32'h10); end
        peek(0, 3, v);
        ntests++;
        if (v !== 32'd0) begin nfail++; $display("FAIL rmid_count got %0d want 0", v); end
        reset = 1;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_overflow();
        test_push_pop_full();
        test_abort();
`ifdef FRAME_CAP_IRQ_EN
        test_irq();
`endif
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
